// File: rtl/xor_descr_pkg.sv
// Shared constants, state type and LFSR step helper for the XOR descrambler.
// Frame length is 9 (8 data + parity) when XOR_DESCR_PARITY_EN is defined, else 8.
package xor_descr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 8'hB8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef XOR_DESCR_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  localparam int CNT_W = 4;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return {s[LFSR_W-2:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/xor_descrambler_lfsr8.sv
// Fibonacci keystream generator: load wins over the stored state, so a bit
// accepted in the load cycle sees seed[7] and the register ends one step past seed.
module lfsr8
  import xor_descr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  input  logic [LFSR_W-1:0] taps,
  output logic [LFSR_W-1:0] state,
  output logic              key_bit
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] base;

  assign base    = load ? seed : state_q;
  assign key_bit = base[LFSR_W-1];
  assign state_d = advance ? lfsr_step(base, taps) : base;
  assign state   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/xor_descrambler.sv
// Serial XOR descrambler with LSB-first byte assembly and a one-deep output register.
// Optional even-parity frame bit and parity_err output under XOR_DESCR_PARITY_EN.
module xor_descrambler
  import xor_descr_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED,
  parameter logic [7:0] TAPS = DEFAULT_TAPS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       sync,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       out_ready,
  output logic       overrun
`ifdef XOR_DESCR_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, bit_idx;
  logic [7:0]       asm_q, asm_d, asm_base, byte_done;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             accept, key_bit, rec_bit, last_bit, handshake;
  logic [7:0]       lfsr_state;
  logic             lfsr_unused;

  // sync in the same cycle as a bit makes that bit index 0 of a fresh frame
  assign accept    = in_valid && ((state_q == RUN) || sync);
  assign rec_bit   = in_bit ^ key_bit;
  assign bit_idx   = sync ? '0 : cnt_q;
  assign asm_base  = sync ? '0 : asm_q;
  assign last_bit  = accept && (bit_idx == CNT_W'(FRAME_LEN - 1));
  assign handshake = valid_q && out_ready;

  // The running state is kept visible for observation only.
  assign lfsr_unused = ^lfsr_state;

  lfsr8 #(
    .RESET_VAL(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load   (sync),
    .seed   (SEED),
    .advance(accept),
    .taps   (TAPS),
    .state  (lfsr_state),
    .key_bit(key_bit)
  );

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_asm
      assign byte_done[gi] = (accept && (bit_idx == CNT_W'(gi))) ? rec_bit : asm_base[gi];
    end
  endgenerate

`ifdef XOR_DESCR_PARITY_EN
  logic par_q, par_d, par_base, perr_q, perr_d;
  assign par_base   = sync ? 1'b0 : par_q;
  assign parity_err = perr_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sync) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = bit_idx;
    asm_d   = asm_base;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = sync ? 1'b0 : ovr_q;
`ifdef XOR_DESCR_PARITY_EN
    par_d   = par_base;
    perr_d  = perr_q;
`endif
    if (accept) begin
      if (last_bit) begin
        cnt_d = '0;
        asm_d = '0;
`ifdef XOR_DESCR_PARITY_EN
        par_d = 1'b0;
`endif
      end else begin
        cnt_d = bit_idx + CNT_W'(1);
        asm_d = byte_done;
`ifdef XOR_DESCR_PARITY_EN
        par_d = par_base ^ rec_bit;
`endif
      end
    end
    // A completing byte may replace one being handed off this same edge.
    if (last_bit) begin
      if (!valid_q || out_ready) begin
        data_d  = byte_done;
        valid_d = 1'b1;
`ifdef XOR_DESCR_PARITY_EN
        perr_d  = par_base ^ rec_bit;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef XOR_DESCR_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef XOR_DESCR_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/xor_descrambler.md
XOR_DESCRAMBLER -- requirements
Module: xor_descrambler

Interface
REQ-001 The block SHALL have parameter SEED, default 8'hA5, which is the LFSR value loaded on reset and on sync.
REQ-002 The block SHALL have parameter TAPS, default 8'hB8, which is the feedback mask (x^8+x^6+x^5+x^4+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge only.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_bit, input, 1 bit: the scrambled serial data bit.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_bit is accepted on every clock edge where in_valid is 1.
REQ-007 The block SHALL have port sync, input, 1 bit: a frame-start pulse that reseeds the LFSR and restarts byte assembly.
REQ-008 The block SHALL have port data_out, output, 8 bits: the recovered byte.
REQ-009 The block SHALL have port data_valid, output, 1 bit: data_out holds a byte not yet accepted.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts data_out when data_valid and out_ready are both 1.
REQ-011 The block SHALL have port overrun, output, 1 bit: a sticky flag meaning a completed byte was dropped.
REQ-012 The block SHALL have port parity_err, output, 1 bit, present only with XOR_DESCR_PARITY_EN: the parity result of the byte in data_out.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN: IDLE moves to RUN on sync=1, and RUN stays in RUN with sync=1 restarting the frame; there SHALL be no other transitions except reset.
REQ-014 In IDLE, in_valid SHALL be ignored and the LFSR SHALL hold its value.
REQ-015 The keystream bit SHALL be lfsr[7]; the recovered bit SHALL be in_bit XOR lfsr[7], combinational on the current LFSR value.
REQ-016 On each accepted bit, the LFSR SHALL shift left with new lfsr[0] = XOR-reduce(lfsr & TAPS).
REQ-017 Recovered bits SHALL be assembled LSB first; the bit counter SHALL wrap to 0 after the last bit of a byte.
REQ-018 sync SHALL load SEED into the LFSR, clear the bit counter and discard any partial byte, whether the block is in IDLE or RUN.
REQ-019 When sync and in_valid are both 1 in the same cycle, that in_bit SHALL be bit 0 of the new frame and SHALL be descrambled with SEED[7].
REQ-020 A completed byte SHALL appear on data_out with data_valid=1 on the edge that accepts its last bit, giving 1-cycle latency from the last bit.
REQ-021 data_out and data_valid SHALL hold their values until a handshake (data_valid=1 and out_ready=1).
REQ-022 A new byte completing on the same edge as a handshake SHALL be loaded, with no bubble and no overrun.
REQ-023 A byte completing while data_valid=1 and out_ready=0 SHALL be dropped, SHALL set overrun, and SHALL leave data_out unchanged.
REQ-024 overrun SHALL be cleared only by reset or by sync.
REQ-025 sync SHALL NOT clear a pending data_valid byte.

Reset
REQ-026 While reset=0, the block SHALL be in IDLE with lfsr=SEED, bit counter=0, data_out=8'h00, data_valid=0, overrun=0 and parity_err=0.
REQ-027 Reset asserted mid-byte or mid-handshake SHALL discard all state immediately, without waiting for a clock edge.
REQ-028 The first edge after reset release SHALL take no action unless sync=1.

Configuration
REQ-029 The configuration macro SHALL be XOR_DESCR_PARITY_EN.
REQ-030 With XOR_DESCR_PARITY_EN defined, each byte frame SHALL be 9 accepted bits: 8 data bits followed by 1 even-parity bit, and the parity bit SHALL also be descrambled and SHALL also advance the LFSR.
REQ-031 With XOR_DESCR_PARITY_EN defined, parity_err SHALL be loaded together with data_out and SHALL be 1 when the XOR of the 8 data bits and the parity bit is 1.
REQ-032 With XOR_DESCR_PARITY_EN defined, a dropped byte SHALL NOT update parity_err.
REQ-033 Without XOR_DESCR_PARITY_EN, each frame SHALL be 8 bits, the parity_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Shared package xor_descr_pkg SHALL hold LFSR_W=8, DEFAULT_SEED, DEFAULT_TAPS, the IDLE/RUN state typedef and the frame-length constant (8 or 9, selected by the macro).
REQ-035 The block SHALL have one sub-module, lfsr8, containing the keystream generator, with inputs load, seed, advance and taps, and outputs state and key_bit; the FSM, assembly and handshake logic SHALL stay in xor_descrambler.

Verification
REQ-036 The bench SHALL apply sync followed by 8 bits equal to the keystream, with out_ready=1, and SHALL check data_out=8'h00, data_valid for exactly 1 cycle, and overrun=0.
REQ-037 The bench SHALL apply sync followed by 8 bits equal to the inverted keystream, and SHALL check data_out=8'hFF.
REQ-038 The bench SHALL apply sync, 5 bits, sync, then 8 bits of the keystream XOR 8'h3C, and SHALL check one byte 8'h3C with the partial byte discarded.
REQ-039 The bench SHALL send two bytes 8'h12 and 8'h34 with out_ready=0, and SHALL check that data_out stays 8'h12, overrun=1, and that after out_ready=1 data_valid falls and overrun holds until the next sync.
REQ-040 The bench SHALL assert reset=0 mid-byte after 4 bits, then apply sync and 8 bits, and SHALL check that only the new byte is output and that lfsr restarts at 8'hA5.
REQ-041 With XOR_DESCR_PARITY_EN defined, the bench SHALL send 8'h07 with the parity bit correct and then with it flipped, and SHALL check parity_err=0 and then parity_err=1.
